parking_lane_arbiter: RTL and testbench

// Shares one parking-lot occupancy counter and gate sequencer between N_LANES

---
 rtl/parking_lane_arbiter_pkg.sv | 21 ++
 rtl/parking_lane_arbiter_if.sv | 42 ++++
 rtl/parking_lane_arbiter_rr_arbiter.sv | 47 ++++
 rtl/parking_lane_arbiter.sv | 155 +++++++++++++++
 tb/tb_parking_lane_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/parking_lane_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// parking_lane_arbiter_pkg
// Shared definitions for the parking lane arbiter: the controller state
// encoding and the default values of its parameters.
// No ports.
// -----------------------------------------------------------------------------
package parking_lane_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_OPEN  = 2'd2,
      ST_CLOSE = 2'd3
   } state_e;

   localparam int         N_LANES_DEFAULT     = 4;
   localparam int         CNT_W_DEFAULT       = 5;
   localparam int         GATE_CYCLES_DEFAULT = 4;
   localparam logic [7:0] PASSCODE_DEFAULT    = 8'hFF;

endpackage

// File: rtl/parking_lane_arbiter_if.sv
// -----------------------------------------------------------------------------
// parking_lane_arbiter_if
// Bundles the lane request side and the lot status side of the arbiter.
//   master : lane front ends / status consumer (drives req, req_exit,
//            passcode, max_capacity; observes the results)
//   slave  : the arbiter itself
// Signals:
//   req, req_exit      per-lane request and direction (0=entry, 1=exit)
//   passcode           per-lane code, lane i = [8*i+7:8*i]
//   max_capacity       lot capacity
//   grant, deny        one-hot single-cycle result pulses
//   gate_open          one-hot open gate, gate_is_exit its direction
//   car_count, lot_full, busy   lot / controller status
// -----------------------------------------------------------------------------
interface parking_lane_arbiter_if
   import parking_lane_arbiter_pkg::*;
#(
   parameter int N_LANES = N_LANES_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
);
   logic [N_LANES-1:0]   req;
   logic [N_LANES-1:0]   req_exit;
   logic [8*N_LANES-1:0] passcode;
   logic [CNT_W-1:0]     max_capacity;
   logic [N_LANES-1:0]   grant;
   logic [N_LANES-1:0]   deny;
   logic [N_LANES-1:0]   gate_open;
   logic                 gate_is_exit;
   logic [CNT_W-1:0]     car_count;
   logic                 lot_full;
   logic                 busy;

   modport master (
      output req, req_exit, passcode, max_capacity,
      input  grant, deny, gate_open, gate_is_exit, car_count, lot_full, busy
   );

   modport slave (
      input  req, req_exit, passcode, max_capacity,
      output grant, deny, gate_open, gate_is_exit, car_count, lot_full, busy
   );
endinterface

// File: rtl/parking_lane_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first unmasked request at or after
// ptr_i, wrapping around.
//   req_i     request vector
//   mask_i    lanes excluded from this pick
//   ptr_i     highest-priority lane index
//   any_o     a winner exists
//   idx_o     winner index
//   onehot_o  winner as a one-hot vector
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_LANES = 4,
   parameter int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
)(
   input  logic [N_LANES-1:0] req_i,
   input  logic [N_LANES-1:0] mask_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               any_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic [N_LANES-1:0] onehot_o
);
   logic [N_LANES-1:0] elig;

   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_elig
         assign elig[gi]     = req_i[gi] & ~mask_i[gi];
         assign onehot_o[gi] = any_o && (idx_o == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      int   lane;
      logic found;
      lane  = 0;
      found = 1'b0;
      idx_o = '0;
      for (int k = 0; k < N_LANES; k++) begin
         lane = (int'(ptr_i) + k) % N_LANES;
         if (!found && elig[lane]) begin
            found = 1'b1;
            idx_o = IDX_W'(lane);
         end
      end
      any_o = found;
   end
endmodule

// File: rtl/parking_lane_arbiter.sv
// -----------------------------------------------------------------------------
// parking_lane_arbiter
// Serves one lane at a time with a shared occupancy counter and gate
// sequencer: IDLE latches a round-robin winner, CHECK decides grant/deny and
// updates the count, OPEN holds the winner's gate for GATE_CYCLES cycles,
// CLOSE drops all gates for one cycle.
//   clk    clock
//   reset  synchronous active-high reset
//   bus    parking_lane_arbiter_if.slave (requests in, results/status out)
// -----------------------------------------------------------------------------
module parking_lane_arbiter
   import parking_lane_arbiter_pkg::*;
#(
   parameter int         N_LANES     = N_LANES_DEFAULT,
   parameter int         CNT_W       = CNT_W_DEFAULT,
   parameter int         GATE_CYCLES = GATE_CYCLES_DEFAULT,
   parameter logic [7:0] PASSCODE    = PASSCODE_DEFAULT
)(
   input logic                   clk,
   input logic                   reset,
   parking_lane_arbiter_if.slave bus
);
   localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int TMR_W = $clog2(GATE_CYCLES + 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic               exit_q, exit_d;
   logic [7:0]         code_q, code_d;
   logic [N_LANES-1:0] mask_q, mask_d;
   logic [N_LANES-1:0] grant_q, grant_d;
   logic [N_LANES-1:0] deny_q, deny_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;

   logic               arb_any;
   logic [IDX_W-1:0]   arb_idx;
   logic [N_LANES-1:0] arb_oh;
   logic [N_LANES-1:0] win_oh;
   logic [7:0]         lane_code [N_LANES];
   logic               check_ok;

   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
         assign lane_code[gi] = bus.passcode[8*gi +: 8];
         assign win_oh[gi]    = (win_q == IDX_W'(gi));
      end
   endgenerate

   rr_arbiter #(.N_LANES(N_LANES), .IDX_W(IDX_W)) u_rr (
      .req_i    (bus.req),
      .mask_i   (mask_q),
      .ptr_i    (rr_ptr_q),
      .any_o    (arb_any),
      .idx_o    (arb_idx),
      .onehot_o (arb_oh)
   );

   // Capacity is compared live so a capacity change during service is honoured.
   always_comb begin
      if (exit_q) check_ok = (count_q != '0);
      else        check_ok = (code_q == PASSCODE) && (count_q < bus.max_capacity);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (arb_any) state_d = ST_CHECK;
         ST_CHECK: state_d = check_ok ? ST_OPEN : ST_IDLE;
         ST_OPEN:  if (tmr_q == '0) state_d = ST_CLOSE;
         ST_CLOSE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      win_d    = win_q;
      exit_d   = exit_q;
      code_d   = code_q;
      rr_ptr_d = rr_ptr_q;
      mask_d   = mask_q;
      count_d  = count_q;
      tmr_d    = tmr_q;
      grant_d  = '0;
      deny_d   = '0;
      case (state_q)
         ST_IDLE: begin
            // The mask only has to cover the first IDLE cycle after an ack.
            mask_d = '0;
            if (arb_any) begin
               win_d  = arb_idx;
               exit_d = |(bus.req_exit & arb_oh);
               code_d = lane_code[arb_idx];
            end
         end
         ST_CHECK: begin
            mask_d   = win_oh;
            rr_ptr_d = (win_q == IDX_W'(N_LANES - 1)) ? '0 : win_q + IDX_W'(1);
            if (check_ok) begin
               grant_d = win_oh;
               tmr_d   = TMR_W'(GATE_CYCLES - 1);
               count_d = exit_q ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
            end else begin
               deny_d = win_oh;
            end
         end
         ST_OPEN: if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         win_q    <= '0;
         exit_q   <= 1'b0;
         code_q   <= '0;
         mask_q   <= '0;
         grant_q  <= '0;
         deny_q   <= '0;
         count_q  <= '0;
         tmr_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         exit_q   <= exit_d;
         code_q   <= code_d;
         mask_q   <= mask_d;
         grant_q  <= grant_d;
         deny_q   <= deny_d;
         count_q  <= count_d;
         tmr_q    <= tmr_d;
      end
   end

   // Outputs
   always_comb begin
      bus.gate_open    = (state_q == ST_OPEN) ? win_oh : '0;
      bus.gate_is_exit = (state_q == ST_OPEN) && exit_q;
      bus.busy         = (state_q != ST_IDLE);
      bus.lot_full     = (count_q >= bus.max_capacity);
      bus.grant        = grant_q;
      bus.deny         = deny_q;
      bus.car_count    = count_q;
   end
endmodule

// File: tb/tb_parking_lane_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_lane_arbiter
// Directed test of the parking lane arbiter with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_parking_lane_arbiter;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   gate_n;

   parking_lane_arbiter_if #(.N_LANES(4), .CNT_W(5)) bus ();

   parking_lane_arbiter #(
      .N_LANES(4), .CNT_W(5), .GATE_CYCLES(4), .PASSCODE(8'hFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the grant/deny pulse of one service, checks it, then
   // drops the lane's request one cycle later as a front end would.
   task automatic expect_service(input int lane, input bit ok, input bit is_exit,
                                 input int exp_count, input string tag);
      int         n;
      logic [3:0] oh;
      oh = 4'(1 << lane);
      n  = 0;
      while ((bus.grant | bus.deny) == 4'b0 && n < 20) begin
         tick(1);
         n++;
      end
      check({tag, "_pulse"}, 32'((bus.grant | bus.deny) != 4'b0), 1);
      check({tag, "_grant"}, bus.grant, ok ? oh : 4'b0);
      check({tag, "_deny"}, bus.deny, ok ? 4'b0 : oh);
      check({tag, "_gate"}, bus.gate_open, ok ? oh : 4'b0);
      check({tag, "_exit"}, bus.gate_is_exit, ok ? is_exit : 1'b0);
      check({tag, "_count"}, bus.car_count, exp_count);
      $display("svc %s lane=%0d grant=%b deny=%b count=%0d",
               tag, lane, bus.grant, bus.deny, bus.car_count);
      tick(1);
      bus.req[lane]      = 1'b0;
      bus.req_exit[lane] = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy && n < 40) begin
         tick(1);
         n++;
      end
      check({tag, "_idle"}, bus.busy, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.req          = '0;
      bus.req_exit     = '0;
      bus.passcode     = {4{8'hFF}};
      bus.max_capacity = 5'd3;
      tick(2);

      // Reset state
      check("rst_busy", bus.busy, 0);
      check("rst_count", bus.car_count, 0);
      check("rst_gate", bus.gate_open, 0);
      check("rst_grant", bus.grant, 0);
      check("rst_deny", bus.deny, 0);
      check("rst_gate_exit", bus.gate_is_exit, 0);
      check("rst_lot_full", bus.lot_full, 0);
      reset = 1'b0;

      // 1: single entry, latency and gate width
      bus.req[0] = 1'b1;
      tick(1);
      check("t1_busy_c1", bus.busy, 1);
      check("t1_grant_c1", bus.grant, 0);
      tick(1);
      check("t1_grant_c2", bus.grant, 4'b0001);
      check("t1_gate_c2", bus.gate_open, 4'b0001);
      check("t1_count_c2", bus.car_count, 1);
      $display("svc t1 lane=0 grant=%b count=%0d", bus.grant, bus.car_count);
      gate_n = 1;
      tick(1);
      bus.req[0] = 1'b0;
      check("t1_grant_c3", bus.grant, 0);
      repeat (5) begin
         if (bus.gate_open == 4'b0001) gate_n++;
         tick(1);
      end
      check("t1_gate_cycles", gate_n, 4);
      check("t1_idle", bus.busy, 0);

      // 2: round-robin order from rr_ptr=0
      reset = 1'b1;
      bus.max_capacity = 5'd10;
      tick(1);
      reset = 1'b0;
      bus.req = 4'b0111;
      expect_service(0, 1, 0, 1, "t2_l0");
      expect_service(1, 1, 0, 2, "t2_l1");
      expect_service(2, 1, 0, 3, "t2_l2");
      bus.req[3] = 1'b1;
      bus.req[0] = 1'b1;
      expect_service(3, 1, 0, 4, "t2_l3");
      expect_service(0, 1, 0, 5, "t2_l0b");

      // 3: wrong code denied, late drop masked, pointer advanced to 2
      bus.passcode[15:8] = 8'h5A;
      bus.req[1] = 1'b1;
      expect_service(1, 0, 0, 5, "t3_badcode");
      check("t3_mask_busy", bus.busy, 0);
      bus.passcode[15:8] = 8'hFF;
      bus.req[1] = 1'b1;
      bus.req[2] = 1'b1;
      expect_service(2, 1, 0, 6, "t3_ptr2");
      expect_service(1, 1, 0, 7, "t3_l1");

      // 4: full lot: entry denied, exit granted
      bus.max_capacity = 5'd7;
      tick(1);
      check("t4_lot_full", bus.lot_full, 1);
      bus.req[0] = 1'b1;
      expect_service(0, 0, 0, 7, "t4_full_entry");
      bus.req_exit[0] = 1'b1;
      bus.req[0]      = 1'b1;
      expect_service(0, 1, 1, 6, "t4_exit");
      check("t4_not_full", bus.lot_full, 0);
      wait_idle("t4");

      // 5: empty exit denied, capacity lowered below count, capacity zero
      reset = 1'b1;
      bus.max_capacity = 5'd5;
      tick(1);
      reset = 1'b0;
      check("t5_count_rst", bus.car_count, 0);
      bus.req_exit[2] = 1'b1;
      bus.req[2]      = 1'b1;
      expect_service(2, 0, 0, 0, "t5_exit_empty");
      bus.req[2] = 1'b1;
      expect_service(2, 1, 0, 1, "t5_in1");
      bus.req[2] = 1'b1;
      expect_service(2, 1, 0, 2, "t5_in2");
      bus.max_capacity = 5'd1;
      tick(1);
      check("t5_lot_full_low", bus.lot_full, 1);
      bus.req[2] = 1'b1;
      expect_service(2, 0, 0, 2, "t5_over_entry");
      bus.req_exit[2] = 1'b1;
      bus.req[2]      = 1'b1;
      expect_service(2, 1, 1, 1, "t5_over_exit");
      check("t5_lot_full_eq", bus.lot_full, 1);
      wait_idle("t5");
      reset = 1'b1;
      bus.max_capacity = 5'd0;
      tick(1);
      reset = 1'b0;
      tick(1);
      check("t5_cap0_full", bus.lot_full, 1);
      bus.req[0] = 1'b1;
      expect_service(0, 0, 0, 0, "t5_cap0_entry");
      check("t5_cap0_full2", bus.lot_full, 1);

      // 6: reset during OPEN, pending requests served from rr_ptr=0
      bus.max_capacity = 5'd10;
      bus.req[2] = 1'b1;
      expect_service(2, 1, 0, 1, "t6_l2");
      bus.req[1] = 1'b1;
      bus.req[3] = 1'b1;
      reset = 1'b1;
      tick(1);
      check("t6_gate_rst", bus.gate_open, 0);
      check("t6_busy_rst", bus.busy, 0);
      check("t6_count_rst", bus.car_count, 0);
      check("t6_grant_rst", bus.grant, 0);
      reset = 1'b0;
      expect_service(1, 1, 0, 1, "t6_l1");
      expect_service(3, 1, 0, 2, "t6_l3");
      wait_idle("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
